// File: rtl/des_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : des_pkg
//  Brief    : DES key-schedule constants (PC1, PC2, shift table), widths,
//             state encoding and 28-bit half-key rotation helpers.
//             Bit index i of any vector corresponds to FIPS bit i+1.
//  Revision : 1.0 - initial release
// ============================================================================
package des_pkg;

    localparam int KEY_W    = 64;
    localparam int CD_W     = 28;
    localparam int SUBKEY_W = 48;

    // PC1: 0-based source bit in Key for each of the 56 C||D bits.
    localparam int c_pc1 [0:55] = '{
        56, 48, 40, 32, 24, 16,  8,
         0, 57, 49, 41, 33, 25, 17,
         9,  1, 58, 50, 42, 34, 26,
        18, 10,  2, 59, 51, 43, 35,
        62, 54, 46, 38, 30, 22, 14,
         6, 61, 53, 45, 37, 29, 21,
        13,  5, 60, 52, 44, 36, 28,
        20, 12,  4, 27, 19, 11,  3
    };

    // PC2: 0-based source bit in C||D (C = 0..27, D = 28..55) per subkey bit.
    localparam int c_pc2 [0:47] = '{
        13, 16, 10, 23,  0,  4,
         2, 27, 14,  5, 20,  9,
        22, 18, 11,  3, 25,  7,
        15,  6, 26, 19, 12,  1,
        40, 51, 30, 36, 46, 54,
        29, 39, 50, 44, 32, 47,
        43, 48, 38, 55, 33, 52,
        45, 41, 49, 35, 28, 31
    };

    // Per-round shift amounts S[1..16], stored 0-based.
    localparam logic [1:0] c_shift [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // Rotate left: new[i] = old[(i+s) mod 28]; s is 1 or 2.
    function automatic logic [CD_W-1:0] rotl28(input logic [CD_W-1:0] x,
                                               input logic [1:0] s);
        return (s == 2'd2) ? {x[1:0], x[CD_W-1:2]} : {x[0], x[CD_W-1:1]};
    endfunction

    // Rotate right: new[i] = old[(i-s) mod 28]; s is 1 or 2.
    function automatic logic [CD_W-1:0] rotr28(input logic [CD_W-1:0] x,
                                               input logic [1:0] s);
        return (s == 2'd2) ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/des_pc2.sv
`default_nettype none
// ============================================================================
//  Module   : des_pc2
//  Brief    : Combinational DES PC2 permutation, 56-bit C||D to 48-bit
//             subkey. Shared with the round datapath.
//  Revision : 1.0 - initial release
// ============================================================================
module des_pc2
    import des_pkg::*;
(
    input  logic [2*CD_W-1:0]   i_cd,
    output logic [SUBKEY_W-1:0] o_subkey
);

    for (genvar i = 0; i < SUBKEY_W; i++) begin : g_pc2
        assign o_subkey[i] = i_cd[c_pc2[i]];
    end

endmodule
`default_nettype wire

// File: rtl/des_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : des_key_scheduler
//  Brief    : Sequential DES round-key generator. Applies PC1 to the key,
//             then streams the 16 subkeys over valid/ready, K1..K16 for
//             encrypt (left rotations) or K16..K1 for decrypt (right).
//  Revision : 1.0 - initial release
// ============================================================================
module des_key_scheduler
    import des_pkg::*;
(
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Start,
    input  logic [KEY_W-1:0]    Key,
    input  logic                Decrypt,
    input  logic                SubKeyReady,
    output logic                SubKeyValid,
    output logic [SUBKEY_W-1:0] SubKey,
    output logic [3:0]          Round,
    output logic                Busy,
    output logic                Done
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_mode;
    logic [3:0]            r_round;
    logic [CD_W-1:0]       r_c;
    logic [CD_W-1:0]       r_d;
    logic [CD_W-1:0]       w_c_nxt;
    logic [CD_W-1:0]       w_d_nxt;
    logic [SUBKEY_W-1:0]   r_subkey;
    logic [SUBKEY_W-1:0]   w_subkey_nxt;
    logic                  r_done;
    logic                  w_load;
    logic                  w_adv;
    logic                  w_last;
    logic [1:0]            w_shamt;
    logic [2*CD_W-1:0]     w_pc1;
    logic [7:0]            w_unused_parity;

    // PC1 permutation of the raw key; parity bits are deliberately dropped.
    for (genvar i = 0; i < 2*CD_W; i++) begin : g_pc1
        assign w_pc1[i] = Key[c_pc1[i]];
    end

    for (genvar j = 0; j < 8; j++) begin : g_parity
        assign w_unused_parity[j] = Key[8*j+7];
    end

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: load on Start in IDLE, advance or finish on handshake.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (Start) begin
                    w_load      = 1'b1;
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (SubKeyReady) begin
                    if (r_round == 4'd15) begin
                        w_last      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_adv = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next C/D: encrypt loads pre-rotated by S[1], decrypt loads C0D0 (= C16D16).
    always_comb begin
        w_c_nxt = r_c;
        w_d_nxt = r_d;
        w_shamt = r_mode ? c_shift[4'd15 - r_round] : c_shift[r_round + 4'd1];
        if (w_load) begin
            if (Decrypt) begin
                w_c_nxt = w_pc1[CD_W-1:0];
                w_d_nxt = w_pc1[2*CD_W-1:CD_W];
            end else begin
                w_c_nxt = rotl28(w_pc1[CD_W-1:0], c_shift[0]);
                w_d_nxt = rotl28(w_pc1[2*CD_W-1:CD_W], c_shift[0]);
            end
        end else if (w_adv) begin
            if (r_mode) begin
                w_c_nxt = rotr28(r_c, w_shamt);
                w_d_nxt = rotr28(r_d, w_shamt);
            end else begin
                w_c_nxt = rotl28(r_c, w_shamt);
                w_d_nxt = rotl28(r_d, w_shamt);
            end
        end
    end

    des_pc2 u_pc2 (
        .i_cd     ({w_d_nxt, w_c_nxt}),
        .o_subkey (w_subkey_nxt)
    );

    // Datapath registers: C/D, mode, round counter, registered subkey, Done pulse.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_mode   <= 1'b0;
            r_round  <= 4'd0;
            r_c      <= '0;
            r_d      <= '0;
            r_subkey <= '0;
            r_done   <= 1'b0;
        end else begin
            r_c    <= w_c_nxt;
            r_d    <= w_d_nxt;
            r_done <= w_last;
            if (w_load) begin
                r_mode  <= Decrypt;
                r_round <= 4'd0;
            end else if (w_adv) begin
                r_round <= r_round + 4'd1;
            end else if (w_last) begin
                r_round <= 4'd0;
            end
            if (w_load || w_adv) begin
                r_subkey <= w_subkey_nxt;
            end
        end
    end

    assign SubKeyValid = (r_state == EMIT);
    assign Busy        = (r_state != IDLE);
    assign SubKey      = r_subkey;
    assign Round       = r_round;
    assign Done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_des_key_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_des_key_scheduler
//  Brief    : Scoreboard bench for des_key_scheduler with a closed-form
//             reference model of the DES key schedule.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic        ready = 1'b0;
    logic [63:0] key = '0;
    logic        sk_valid;
    logic [47:0] subkey;
    logic [3:0]  round;
    logic        busy;
    logic        done;

    des_key_scheduler dut (
        .Clk         (clk),
        .Rst         (rst),
        .Start       (start),
        .Key         (key),
        .Decrypt     (decrypt),
        .SubKeyReady (ready),
        .SubKeyValid (sk_valid),
        .SubKey      (subkey),
        .Round       (round),
        .Busy        (busy),
        .Done        (done)
    );

    always #5 clk = ~clk;

    // FIPS tables, 1-based as published.
    int pc1_t [56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                       19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                       14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
    int pc2_t [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                       41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
    int sh_t  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

    typedef struct packed {
        logic [47:0] key;
        logic [3:0]  rnd;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [47:0] obs_q[$];
    logic [47:0] saved_q[$];
    logic [47:0] ks [16];
    logic        done_pending = 1'b0;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [63:0] rev64(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = x[63-i];
        return r;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] x);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = x[47-i];
        return r;
    endfunction

    task automatic check(input bit ok, input string name,
                         input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference: Kn = PC2(C0<<<tot, D0<<<tot) with tot = S[1]+..+S[n]; FIPS hex order.
    task automatic build(input logic [63:0] khex);
        int tot;
        int p;
        int q;
        tot = 0;
        for (int n = 0; n < 16; n++) begin
            tot += sh_t[n];
            for (int j = 0; j < 48; j++) begin
                p = pc2_t[j];
                if (p <= 28) q = (p - 1 + tot) % 28;
                else         q = 28 + (p - 29 + tot) % 28;
                ks[n][47-j] = khex[64 - pc1_t[q]];
            end
        end
    endtask

    task automatic push_sched(input bit dec);
        exp_t e;
        for (int r = 0; r < 16; r++) begin
            e.key  = dec ? ks[15-r] : ks[r];
            e.rnd  = 4'(r);
            e.last = (r == 15);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pop on every handshake, track the Done pulse after the last key.
    always @(negedge clk) begin
        if (!rst) begin
            check(done === done_pending, "done_pulse", {63'd0, done}, {63'd0, done_pending});
            done_pending = 1'b0;
            if (sk_valid && ready) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_key", {16'd0, rev48(subkey)}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check(rev48(subkey) === mon_e.key, "subkey", {16'd0, rev48(subkey)}, {16'd0, mon_e.key});
                    check(round === mon_e.rnd, "round", {60'd0, round}, {60'd0, mon_e.rnd});
                    obs_q.push_back(rev48(subkey));
                    if (mon_e.last) done_pending = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue Start in an IDLE cycle; Key/Decrypt are scrambled afterwards.
    task automatic start_sched(input logic [63:0] khex, input bit dec);
        build(khex);
        start   = 1'b1;
        key     = rev64(khex);
        decrypt = dec;
        push_sched(dec);
        tick();
        start   = 1'b0;
        key     = {$urandom, $urandom};
        decrypt = 1'($urandom % 2);
        check(sk_valid && round == 4'd0, "first_key_latency", {59'd0, sk_valid, round}, 64'h10);
    endtask

    task automatic drain(input bit rand_ready);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || done_pending) && n < 400) begin
            if (rand_ready) ready = (($urandom % 4) != 0);
            tick();
            n++;
        end
        ready = 1'b1;
        check(exp_q.size() == 0 && !done_pending, "drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_round(input logic [3:0] r);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (sk_valid && round == r) found = 1'b1;
            else tick();
        end
        check(found, "wait_round_timeout", {60'd0, round}, {60'd0, r});
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] ka;
        logic [63:0] kb;
        logic [63:0] kc;

        // Reset state
        repeat (3) tick();
        check(sk_valid == 1'b0, "rst_valid", {63'd0, sk_valid}, 64'd0);
        check(busy == 1'b0, "rst_busy", {63'd0, busy}, 64'd0);
        check(done == 1'b0, "rst_done", {63'd0, done}, 64'd0);
        check(subkey == 48'd0, "rst_subkey", {16'd0, subkey}, 64'd0);
        check(round == 4'd0, "rst_round", {60'd0, round}, 64'd0);
        rst   = 1'b0;
        ready = 1'b1;
        tick();

        // Known-answer encrypt
        obs_q.delete();
        start_sched(64'h133457799BBCDFF1, 1'b0);
        drain(1'b0);
        check(obs_q.size() == 16, "enc_count", 64'(obs_q.size()), 64'd16);
        check(obs_q[0] == 48'h1B02EFFC7072, "enc_k1", {16'd0, obs_q[0]}, 64'h1B02EFFC7072);
        check(obs_q[1] == 48'h79AED9DBC9E5, "enc_k2", {16'd0, obs_q[1]}, 64'h79AED9DBC9E5);
        check(obs_q[15] == 48'hCB3D8B0E17F5, "enc_k16", {16'd0, obs_q[15]}, 64'hCB3D8B0E17F5);
        saved_q = obs_q;

        // Known-answer decrypt: exact reverse of encrypt
        obs_q.delete();
        start_sched(64'h133457799BBCDFF1, 1'b1);
        drain(1'b0);
        check(obs_q.size() == 16, "dec_count", 64'(obs_q.size()), 64'd16);
        check(obs_q[0] == 48'hCB3D8B0E17F5, "dec_first", {16'd0, obs_q[0]}, 64'hCB3D8B0E17F5);
        check(obs_q[15] == 48'h1B02EFFC7072, "dec_last", {16'd0, obs_q[15]}, 64'h1B02EFFC7072);
        for (int i = 0; i < 16; i++)
            check(obs_q[i] == saved_q[15-i], "dec_reverse", {16'd0, obs_q[i]}, {16'd0, saved_q[15-i]});

        // Backpressure at Round 3
        obs_q.delete();
        ka = {$urandom, $urandom};
        start_sched(ka, 1'b0);
        wait_round(4'd3);
        ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check(sk_valid == 1'b1, "bp_valid", {63'd0, sk_valid}, 64'd1);
            check(round == 4'd3, "bp_round", {60'd0, round}, 64'd3);
            check(rev48(subkey) == ks[3], "bp_subkey", {16'd0, rev48(subkey)}, {16'd0, ks[3]});
        end
        ready = 1'b1;
        tick();
        check(round == 4'd4, "bp_release", {60'd0, round}, 64'd4);
        drain(1'b0);
        check(obs_q.size() == 16, "bp_count", 64'(obs_q.size()), 64'd16);

        // Start ignored while busy and at final handshake; accepted in Done cycle
        obs_q.delete();
        ka = {$urandom, $urandom};
        kb = {$urandom, $urandom};
        kc = {$urandom, $urandom};
        start_sched(ka, 1'b0);
        wait_round(4'd7);
        start = 1'b1; key = rev64(kb); decrypt = 1'b1;
        tick();
        start = 1'b0;
        wait_round(4'd15);
        start = 1'b1; key = rev64(kb); decrypt = 1'b1;
        tick();
        check(busy == 1'b0 && done == 1'b1, "done_cycle_idle", {62'd0, busy, done}, 64'h1);
        start_sched(kc, 1'b0);
        drain(1'b0);
        check(obs_q.size() == 32, "start_ignore_count", 64'(obs_q.size()), 64'd32);

        // Reset mid-schedule at Round 9
        ka = {$urandom, $urandom};
        start_sched(ka, 1'b0);
        wait_round(4'd9);
        rst   = 1'b1;
        ready = 1'b0;
        tick();
        rst = 1'b0;
        exp_q.delete();
        done_pending = 1'b0;
        check(busy == 1'b0, "rst_mid_busy", {63'd0, busy}, 64'd0);
        check(sk_valid == 1'b0, "rst_mid_valid", {63'd0, sk_valid}, 64'd0);
        check(done == 1'b0, "rst_mid_done", {63'd0, done}, 64'd0);
        ready = 1'b1;
        obs_q.delete();
        start_sched(ka, 1'b0);
        drain(1'b0);
        check(obs_q[0] == ks[0], "rst_restart_k1", {16'd0, obs_q[0]}, {16'd0, ks[0]});

        // Parity bits have no influence
        obs_q.delete();
        ka = {$urandom, $urandom};
        start_sched(ka, 1'b0);
        drain(1'b0);
        saved_q = obs_q;
        obs_q.delete();
        start_sched(ka ^ 64'h0101010101010101, 1'b0);
        drain(1'b0);
        check(obs_q.size() == 16, "parity_count", 64'(obs_q.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            check(obs_q[i] == saved_q[i], "parity_equal", {16'd0, obs_q[i]}, {16'd0, saved_q[i]});

        // Random keys, directions and ready patterns
        for (int n = 0; n < 6; n++) begin
            ka = {$urandom, $urandom};
            start_sched(ka, 1'($urandom % 2));
            drain(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/des_key_scheduler.md
Name: des_key_scheduler

Overview:
- Sequential DES round-key generator; sits between the key register and the round datapath.
- Takes a 64-bit key, applies PC1, then streams the 16 48-bit round subkeys one at a time over a valid/ready handshake.
- Supports forward order (encrypt: K1..K16, left rotations) and reverse order (decrypt: K16..K1, right rotations), so one block serves both directions.

Parameters:
- none (DES geometry is fixed; constants live in the package)

Ports:
- Clk  input  1  rising-edge clock
- Rst  input  1  synchronous, active-high reset
- Start  input  1  request a new schedule; sampled only in IDLE
- Key  input  64  raw key incl. parity bits; index i = FIPS bit i+1
- Decrypt  input  1  sampled with Start; 1 = emit K16 first
- SubKeyReady  input  1  consumer accepts SubKey this cycle
- SubKeyValid  output  1  SubKey/Round valid
- SubKey  output  48  PC2(C||D); index i = FIPS bit i+1
- Round  output  4  index of the key being offered, 0..15 in emission order
- Busy  output  1  high while not IDLE
- Done  output  1  one-cycle pulse after the 16th handshake

Behaviour:
- One clock and one reset; reset is synchronous and active-high.
- Reset values: state IDLE; SubKeyValid, Busy and Done = 0; SubKey = 0; Round = 0; C and D = 0.
- Rst overrides everything, including mid-schedule. The next cycle is IDLE with no Done.
- PC1 maps Key to 56 bits. C = PC1 bits 0..27, D = PC1 bits 28..55.
- Rotation convention: a rotate-left by s gives new[i] = old[(i+s) mod 28]. A rotate-right by s gives new[i] = old[(i-s) mod 28].
- Shift table S[1..16] = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 (sum 28).
- States:
  - IDLE: Start=1 at edge T → latch Decrypt into mode, load C/D.
    - Encrypt: C/D are loaded already rotated left by S[1].
    - Decrypt: C/D are loaded unrotated, because C16D16 = C0D0.
    - Go to EMIT with SubKeyValid=1, Round=0 at T+1.
  - EMIT: SubKey = PC2(C||D), registered so it is stable while valid.
    - SubKeyValid=1 and SubKeyReady=0: SubKey and Round hold unchanged (backpressure, any duration).
    - Handshake with Round = r < 15:
      - Encrypt: rotate left by S[r+2].
      - Decrypt: rotate right by S[16-r].
      - Round increments; the new key is valid on the next cycle, giving one key per cycle when Ready is held high.
    - Handshake with Round = 15: go to IDLE, SubKeyValid=0, Done=1 for exactly one cycle.
- Latency: first key 1 cycle after Start accepted. A full schedule under constant Ready takes 16 cycles, then Done.
- Start while Busy is ignored, and the in-flight schedule is unaffected.
- Start in the same cycle as the final handshake is ignored, because the state is still EMIT.
- Start in the cycle Done=1 is accepted (state is IDLE).
- Key and Decrypt are sampled only at the Start edge. Later changes have no effect.
- Parity bits (indices 7,15,…,63) never influence SubKey.
- After all 16 rotations, C/D equal the loaded C0/D0 in both modes. This is the sanity property for assertions.

Decomposition:
- Package des_pkg holds:
  - PC1 table (56 entries) and PC2 table (48 entries), as 0-based source indices in the index convention above.
  - Shift table S.
  - Width constants KEY_W=64, CD_W=28, SUBKEY_W=48.
  - State enum {IDLE, EMIT}.
- Sub-module des_pc2: purely combinational 56→48 PC2 permutation from the package table, reusable by the round datapath.
- PC1 and the rotators stay inline.

Test Plan:
- Hex values are written in FIPS order, so the leftmost bit is index 0.
- Encrypt, key 133457799BBCDFF1, Ready=1: Start → next cycle SubKey=1B02EFFC7072, Round=0; following cycle 79AED9DBC9E5; 16th key CB3D8B0E17F5; Done exactly one cycle after it.
- Decrypt, same key: first SubKey=CB3D8B0E17F5, second = the encrypt 15th key, last = 1B02EFFC7072. Check the sequence is the exact reverse of the encrypt run.
- Backpressure: hold Ready=0 for 5 cycles at Round=3 → SubKey and Round stable and SubKeyValid=1 throughout; release → Round=4 on the next cycle; total keys still 16.
- Start pulsed at Round=7 with a different key, and again coincident with the final handshake → both ignored, emitted sequence unchanged; Start during the Done cycle → new schedule begins.
- Rst asserted at Round=9 → next cycle Busy=0, SubKeyValid=0, Done=0; a fresh Start yields K1 again.
- Flip all parity bits of the key → sequence identical to the unflipped run.
